param_bank_loader: RTL
======================

# param_bank_loader

Parametrised, double-buffered weight/bias loader for one layer. On `start` it streams `w_count` weights from `w_base` and `b_count` biases from `b_base` over the byte memory request/response port, and keeps up to `MAX_OUT` requests in flight under `mem_req_ready` backpressure. It writes the returned data into the shadow bank and, on completion, swaps the shadow bank with the active bank. The conv datapath reads the active bank through registered read ports, so compute on one layer overlaps loading of the next.

## Interface
- `DATA_W`, 8: width of each weight/bias word and of `mem_resp_data`.
- `ADDR_W`, 32: memory address width.
- `W_MAX`, 1024: weight capacity per bank.
- `B_MAX`, 64: bias capacity per bank.
- `MAX_OUT`, 4: maximum outstanding (accepted, unanswered) requests; must be ≥1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle load request; honoured only in IDLE.
- `w_base`, `b_base`  in  `ADDR_W`  start addresses of the weight and bias regions.
- `w_count`  in  `$clog2(W_MAX+1)`  number of weights to load.
- `b_count`  in  `$clog2(B_MAX+1)`  number of biases to load.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  one-cycle pulse; the counts were out of range and the load was rejected.
- `active_bank`  out  1  bank visible on the read ports.
- `mem_req_valid`  out  1  read request valid.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_write`  out  1  constant 0.
- `mem_req_addr`  out  `ADDR_W`  request address.
- `mem_resp_valid`  in  1  in-order response valid.
- `mem_resp_data`  in  `DATA_W`  response data.
- `rd_w_addr`  in  `$clog2(W_MAX)`  weight read address into the active bank.
- `rd_w_data`  out  `DATA_W`  weight read data.
- `rd_b_addr`  in  `$clog2(B_MAX)`  bias read address into the active bank.
- `rd_b_data`  out  `DATA_W`  bias read data.

## Operation
States:
- **IDLE**: on `start`:
  - if `w_count>W_MAX` or `b_count>B_MAX`, go to ERR;
  - else if `w_count+b_count==0`, go to DONE;
  - else latch bases and counts, clear `req_idx`, `rsp_idx` and `outstanding`, and go to ISSUE.
- **ISSUE**:
  - `mem_req_valid = (outstanding < MAX_OUT)`, using the registered value.
  - `mem_req_addr = (req_idx < w_count) ? w_base+req_idx : b_base+(req_idx-w_count)`.
  - On `valid && ready`, increment `req_idx`.
  - Go to DRAIN after the last request (`N = w_count + b_count`) is accepted.
- **DRAIN**: no requests. Go to DONE on the cycle the last response is written.
- **DONE**: `done=1` and `active_bank` toggles on the same edge. Return to IDLE.
- **ERR**: `error=1`. Nothing is issued or written and the bank is unchanged. Return to IDLE.

Response handling and counters:
- In ISSUE/DRAIN, each `mem_resp_valid` writes into the shadow bank (`~active_bank`):
  - `rsp_idx < w_count` → weight entry `rsp_idx`;
  - otherwise → bias entry `rsp_idx - w_count`.
- `outstanding` increments on accept and decrements on response; a simultaneous accept and response leaves it unchanged. It never exceeds `MAX_OUT`.
- Responses in IDLE/DONE/ERR are ignored.
- `start` while busy is ignored.
- Read ports are registered, 1-cycle latency, and always read `active_bank`. A read issued in the DONE cycle returns old-bank data; reads from the next cycle onward see the new bank.
- Address arithmetic is modulo 2^`ADDR_W`; wrap-around is not flagged.

## Timing
- Reset values: all outputs 0; `active_bank=0`; state IDLE; counters 0. Bank RAM contents are not reset.
- Reset mid-load aborts immediately: no `done`, no bank swap, and partially written shadow data is discarded logically.
- With `start` sampled at edge 0, `ready=1` and 1-cycle response latency:
  - requests in cycles 1..N;
  - responses in cycles 2..N+1;
  - `done` in cycle N+2.
- `N=0`: `done` in cycle 1.
- Rejected counts: `error` in cycle 1.

## Structure
- Package `param_loader_pkg`: state encoding (IDLE, ISSUE, DRAIN, DONE, ERR) and count/address width helper functions.
- Submodule `param_bank_ram #(DATA_W, DEPTH)`:
  - two banks;
  - one synchronous write port, bank-select plus address;
  - one registered read port.
- It is instantiated once for weights (`DEPTH=W_MAX`) and once for biases (`DEPTH=B_MAX`).

## Test plan
- **Layer-1 load**: `w_count=756`, `b_count=28`, bases 0/756, `ready=1`, 1-cycle memory preloaded from the conv kernel/bias mem files → `done` at cycle 786, `active_bank=1`, all 756 weights and 28 biases read back equal to the file values.
- **Backpressure**: `mem_req_ready` pseudo-random at 50% → no duplicated or skipped addresses, `outstanding ≤ 4` every cycle, data identical to the layer-1 load.
- **Latency limit**: memory latency 6 cycles, `MAX_OUT=4` → exactly 4 requests before the first response, `valid` low while 4 are in flight, correct data.
- **Ping-pong**: load A (values `i`), then start load B (values `255-i`) while continuously reading weight 5 → reads return 5 until the cycle after B's `done`, then 250; `active_bank` back to 0.
- **Bad and empty counts**: `w_count=W_MAX+1` → `error` at cycle 1, no requests, `active_bank` unchanged. Both counts 0 → `done` at cycle 1, bank toggles.
- **Reset and ignored start**: assert `rst` after 100 requests → all outputs 0, `active_bank=0`; a full reload then passes. A `start` pulsed mid-load is ignored, with no extra requests.

Source files
------------

// File: rtl/param_loader_pkg.sv
// Shared state encoding and width helpers for the double-buffered parameter loader.
package param_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  // Bits needed to hold a count in the inclusive range 0..max_val.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  // Bits needed to address depth entries (at least one bit).
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/param_bank_ram.sv
// Two-bank RAM: one synchronous write port (bank + address) and one registered read port.
module param_bank_ram
  import param_loader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     wr_bank,
  input  logic [idx_w(DEPTH)-1:0]  wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_bank,
  input  logic [idx_w(DEPTH)-1:0]  rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [2][DEPTH];

  // NOTE: the storage array is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: rtl/param_bank_loader.sv
// Streams one layer's weights and biases into the shadow bank, then swaps banks on completion.
module param_bank_loader
  import param_loader_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 32,
  parameter int W_MAX   = 1024,
  parameter int B_MAX   = 64,
  parameter int MAX_OUT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          w_base,
  input  logic [ADDR_W-1:0]          b_base,
  input  logic [$clog2(W_MAX+1)-1:0] w_count,
  input  logic [$clog2(B_MAX+1)-1:0] b_count,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic                       active_bank,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic                       mem_req_write,
  output logic [ADDR_W-1:0]          mem_req_addr,
  input  logic                       mem_resp_valid,
  input  logic [DATA_W-1:0]          mem_resp_data,
  input  logic [$clog2(W_MAX)-1:0]   rd_w_addr,
  output logic [DATA_W-1:0]          rd_w_data,
  input  logic [$clog2(B_MAX)-1:0]   rd_b_addr,
  output logic [DATA_W-1:0]          rd_b_data
);

  localparam int WC_W  = cnt_w(W_MAX);
  localparam int BC_W  = cnt_w(B_MAX);
  localparam int IDX_W = cnt_w(W_MAX + B_MAX);
  localparam int OUT_W = cnt_w(MAX_OUT);
  localparam int WA_W  = idx_w(W_MAX);
  localparam int BA_W  = idx_w(B_MAX);

  localparam logic [WC_W-1:0]  W_MAX_C   = WC_W'(W_MAX);
  localparam logic [BC_W-1:0]  B_MAX_C   = BC_W'(B_MAX);
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [OUT_W-1:0] OUT_ONE   = OUT_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] w_base_q, b_base_q;
  logic [IDX_W-1:0]  w_cnt_q, n_q, req_idx, rsp_idx;
  logic [OUT_W-1:0]  outstanding;

  logic req_fire, rsp_fire, rsp_last, rsp_is_w, req_is_w;

  assign mem_req_write = 1'b0;
  assign mem_req_valid = (state == S_ISSUE) && (outstanding < MAX_OUT_C);
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign req_is_w      = req_idx < w_cnt_q;
  assign mem_req_addr  = req_is_w ? w_base_q + ADDR_W'(req_idx)
                                  : b_base_q + ADDR_W'(req_idx - w_cnt_q);

  // Responses outside a load, or beyond the expected count, are dropped.
  assign rsp_fire = mem_resp_valid && (state == S_ISSUE || state == S_DRAIN) && (rsp_idx < n_q);
  assign rsp_last = rsp_fire && (rsp_idx == n_q - IDX_ONE);
  assign rsp_is_w = rsp_idx < w_cnt_q;

  // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      active_bank <= 1'b0;
      w_base_q    <= '0;
      b_base_q    <= '0;
      w_cnt_q     <= '0;
      n_q         <= '0;
      req_idx     <= '0;
      rsp_idx     <= '0;
      outstanding <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (req_fire) req_idx <= req_idx + IDX_ONE;
      if (rsp_fire) rsp_idx <= rsp_idx + IDX_ONE;
      if (req_fire && !rsp_fire)      outstanding <= outstanding + OUT_ONE;
      else if (!req_fire && rsp_fire) outstanding <= outstanding - OUT_ONE;

      if (rsp_last) begin
        state       <= S_DONE;
        done        <= 1'b1;
        busy        <= 1'b0;
        active_bank <= ~active_bank;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (w_count > W_MAX_C || b_count > B_MAX_C) begin
                state <= S_ERR;
                error <= 1'b1;
              end else if (w_count == '0 && b_count == '0) begin
                state       <= S_DONE;
                done        <= 1'b1;
                active_bank <= ~active_bank;
              end else begin
                state       <= S_ISSUE;
                busy        <= 1'b1;
                w_base_q    <= w_base;
                b_base_q    <= b_base;
                w_cnt_q     <= IDX_W'(w_count);
                n_q         <= IDX_W'(w_count) + IDX_W'(b_count);
                req_idx     <= '0;
                rsp_idx     <= '0;
                outstanding <= '0;
              end
            end
          end
          S_ISSUE: if (req_fire && req_idx == n_q - IDX_ONE) state <= S_DRAIN;
          S_DRAIN: state <= S_DRAIN;
          S_DONE,
          S_ERR:   state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  param_bank_ram #(.DATA_W(DATA_W), .DEPTH(W_MAX)) u_w_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (rsp_fire && rsp_is_w),
    .wr_bank (~active_bank),
    .wr_addr (WA_W'(rsp_idx)),
    .wr_data (mem_resp_data),
    .rd_bank (active_bank),
    .rd_addr (rd_w_addr),
    .rd_data (rd_w_data)
  );

  param_bank_ram #(.DATA_W(DATA_W), .DEPTH(B_MAX)) u_b_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (rsp_fire && !rsp_is_w),
    .wr_bank (~active_bank),
    .wr_addr (BA_W'(rsp_idx - w_cnt_q)),
    .wr_data (mem_resp_data),
    .rd_bank (active_bank),
    .rd_addr (rd_b_addr),
    .rd_data (rd_b_data)
  );

endmodule
